// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Pipeline-stage register with a valid/ready handshake and a 2-entry skid
//   buffer. Upstream ready depends only on registered state and Hold, so
//   there is no combinational path from OutReady to InReady. The block also
//   provides synchronous flush (bubble injection), a freeze input, an
//   occupancy output and a saturating back-pressure counter.
//
// Parameters
//   DATA_W          payload width in bits (>= 1)
//   CLEAR_ON_FLUSH  1: flush zeroes both payload registers; 0: payloads kept
//   CNT_W           width of the back-pressure counter (>= 1)
//
// Ports
//   CLK       in   rising-edge clock
//   ResetN    in   asynchronous active-low reset
//   InValid   in   upstream offers InData
//   InData    in   upstream payload
//   InReady   out  stage can accept this cycle
//   OutValid  out  OutData is valid
//   OutData   out  payload presented downstream
//   OutReady  in   downstream accepts
//   Flush     in   synchronous discard of held entries and this cycle's input
//   Hold      in   freeze: no transfer on either side
//   Count     out  occupancy, 0..2
//   StallCnt  out  saturating count of back-pressured cycles

module pipe_skid_reg #(
  parameter int unsigned DATA_W         = 64,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              InValid,
  input  logic [DATA_W-1:0] InData,
  output logic              InReady,
  output logic              OutValid,
  output logic [DATA_W-1:0] OutData,
  input  logic              OutReady,
  input  logic              Flush,
  input  logic              Hold,
  output logic [1:0]        Count,
  output logic [CNT_W-1:0]  StallCnt
);

  // State encoding is the pair {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              emit;
  logic              stall;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic. Flush wins over everything; Hold needs no explicit
  // term because it already masks InReady and OutValid, which kills both
  // accept and emit.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) state_nxt = ONE;
        end
        ONE: begin
          if (accept && !emit)      state_nxt = FULL;
          else if (emit && !accept) state_nxt = EMPTY;
        end
        FULL: begin
          if (emit) state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output / handshake logic (depends on registered state and Hold only,
  // plus the qualifying Flush for the internal transfer strobes)
  // ---------------------------------------------------------------------
  always_comb begin
    main_valid = state[0];
    skid_valid = state[1];
    InReady    = !skid_valid && !Hold;
    OutValid   = main_valid && !Hold;
    OutData    = main_data;
    Count      = 2'(main_valid) + 2'(skid_valid);
    accept     = InValid && InReady && !Flush;
    emit       = OutValid && OutReady && !Flush;
    stall      = OutValid && !OutReady && !Flush;
  end

  // ---------------------------------------------------------------------
  // Payload registers. Main always holds the older entry; Skid the younger.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      main_data <= '0;
      skid_data <= '0;
    end else if (Flush) begin
      if (CLEAR_ON_FLUSH) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) main_data <= InData;
        end
        ONE: begin
          // With a simultaneous emit the new beat goes straight to Main;
          // otherwise it lands in Skid behind the current Main entry.
          if (accept && emit) main_data <= InData;
          else if (accept)    skid_data <= InData;
        end
        FULL: begin
          if (emit) begin
            main_data <= skid_data;
            skid_data <= '0;
          end
        end
        default: begin
          main_data <= '0;
          skid_data <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Back-pressure counter: saturates at all-ones, cleared only by reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      StallCnt <= '0;
    end else if (stall && (StallCnt != '1)) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  logic        CLK;
  logic        ResetN;
  logic        InValid;
  logic [63:0] InData;
  logic        InReady;
  logic        OutValid;
  logic [63:0] OutData;
  logic        OutReady;
  logic        Flush;
  logic        Hold;
  logic [1:0]  Count;
  logic [15:0] StallCnt;

  // Second instance: narrow payload, payload kept on flush, 2-bit counter.
  logic        s_InReady;
  logic        s_OutValid;
  logic [7:0]  s_OutData;
  logic [1:0]  s_Count;
  logic [1:0]  s_StallCnt;

  int unsigned tests;
  int unsigned fails;

  pipe_skid_reg #(
    .DATA_W(64),
    .CLEAR_ON_FLUSH(1'b1),
    .CNT_W(16)
  ) dut (
    .CLK(CLK), .ResetN(ResetN),
    .InValid(InValid), .InData(InData), .InReady(InReady),
    .OutValid(OutValid), .OutData(OutData), .OutReady(OutReady),
    .Flush(Flush), .Hold(Hold), .Count(Count), .StallCnt(StallCnt)
  );

  pipe_skid_reg #(
    .DATA_W(8),
    .CLEAR_ON_FLUSH(1'b0),
    .CNT_W(2)
  ) dut_s (
    .CLK(CLK), .ResetN(ResetN),
    .InValid(InValid), .InData(InData[7:0]), .InReady(s_InReady),
    .OutValid(s_OutValid), .OutData(s_OutData), .OutReady(OutReady),
    .Flush(Flush), .Hold(Hold), .Count(s_Count), .StallCnt(s_StallCnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] sat_exp [6];
    tests    = 0;
    fails    = 0;
    ResetN   = 1'b0;
    InValid  = 1'b0;
    InData   = '0;
    OutReady = 1'b0;
    Flush    = 1'b0;
    Hold     = 1'b0;
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3; sat_exp[5] = 2'd3;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_outvalid", 64'(OutValid), 64'd0);
    chk("rst_outdata",  OutData, 64'd0);
    chk("rst_count",    64'(Count), 64'd0);
    chk("rst_stall",    64'(StallCnt), 64'd0);
    chk("rst_inready",  64'(InReady), 64'd1);

    // ---------------- stream 1,2,3 ----------------
    ResetN = 1'b1; InValid = 1'b1; InData = 64'h1; OutReady = 1'b1;
    tick();
    chk("s1_valid", 64'(OutValid), 64'd1);
    chk("s1_data",  OutData, 64'h1);
    chk("s1_count", 64'(Count), 64'd1);
    InData = 64'h2;
    tick();
    chk("s2_data",  OutData, 64'h2);
    chk("s2_count", 64'(Count), 64'd1);
    InData = 64'h3;
    tick();
    chk("s3_data",  OutData, 64'h3);
    chk("s3_count", 64'(Count), 64'd1);
    InValid = 1'b0;
    tick();
    chk("s_drain_valid", 64'(OutValid), 64'd0);
    chk("s_drain_count", 64'(Count), 64'd0);
    chk("s_stall",       64'(StallCnt), 64'd0);

    // ---------------- back-pressure A,B,(C held off) ----------------
    OutReady = 1'b0; InValid = 1'b1; InData = 64'hA;
    tick();
    chk("bp_a_count",   64'(Count), 64'd1);
    chk("bp_a_data",    OutData, 64'hA);
    chk("bp_a_inready", 64'(InReady), 64'd1);
    InData = 64'hB;
    tick();
    chk("bp_b_count",   64'(Count), 64'd2);
    chk("bp_b_inready", 64'(InReady), 64'd0);
    chk("bp_b_stall",   64'(StallCnt), 64'd1);
    chk("bp_b_data",    OutData, 64'hA);
    InData = 64'hC;
    tick();
    chk("bp_c_count", 64'(Count), 64'd2);
    chk("bp_c_data",  OutData, 64'hA);
    chk("bp_c_stall", 64'(StallCnt), 64'd2);
    OutReady = 1'b1;
    tick();
    chk("bp_emit_a_data",    OutData, 64'hB);
    chk("bp_emit_a_count",   64'(Count), 64'd1);
    chk("bp_emit_a_inready", 64'(InReady), 64'd1);
    tick();
    chk("bp_emit_b_data",  OutData, 64'hC);
    chk("bp_emit_b_count", 64'(Count), 64'd1);
    InValid = 1'b0;
    tick();
    chk("bp_done_count", 64'(Count), 64'd0);
    chk("bp_done_valid", 64'(OutValid), 64'd0);
    chk("bp_done_stall", 64'(StallCnt), 64'd2);

    // ---------------- flush from FULL ----------------
    OutReady = 1'b0; InValid = 1'b1; InData = 64'hA;
    tick();
    InData = 64'hB;
    tick();
    chk("fl_full_count", 64'(Count), 64'd2);
    chk("fl_full_stall", 64'(StallCnt), 64'd3);
    Flush = 1'b1; InData = 64'hC;
    tick();
    chk("fl_count",     64'(Count), 64'd0);
    chk("fl_valid",     64'(OutValid), 64'd0);
    chk("fl_data",      OutData, 64'd0);
    chk("fl_stall",     64'(StallCnt), 64'd3);
    chk("fl_inready",   64'(InReady), 64'd1);
    chk("fl_s_valid",   64'(s_OutValid), 64'd0);
    chk("fl_s_keep",    64'(s_OutData), 64'hA);
    chk("fl_s_count",   64'(s_Count), 64'd0);
    Flush = 1'b0; InValid = 1'b0;
    tick();
    chk("fl_idle_count", 64'(Count), 64'd0);
    chk("fl_idle_data",  OutData, 64'd0);

    // ---------------- hold while ONE ----------------
    InValid = 1'b1; InData = 64'hD;
    tick();
    chk("hd_one_count", 64'(Count), 64'd1);
    Hold = 1'b1; OutReady = 1'b1; InData = 64'hE;
    #1;
    chk("hd_outvalid", 64'(OutValid), 64'd0);
    chk("hd_inready",  64'(InReady), 64'd0);
    tick();
    tick();
    chk("hd_count",    64'(Count), 64'd1);
    chk("hd_data",     OutData, 64'hD);
    chk("hd_stall",    64'(StallCnt), 64'd3);
    chk("hd_outvalid2", 64'(OutValid), 64'd0);
    Hold = 1'b0;
    #1;
    chk("hd_rel_valid",   64'(OutValid), 64'd1);
    chk("hd_rel_inready", 64'(InReady), 64'd1);
    tick();
    chk("hd_rel_data",  OutData, 64'hE);
    chk("hd_rel_count", 64'(Count), 64'd1);
    InValid = 1'b0;
    tick();
    chk("hd_done_count", 64'(Count), 64'd0);

    // ---------------- async reset mid-stream ----------------
    OutReady = 1'b0; InValid = 1'b1; InData = 64'h11;
    tick();
    InData = 64'h22;
    tick();
    chk("ar_pre_count", 64'(Count), 64'd2);
    chk("ar_pre_stall", 64'(StallCnt), 64'd4);
    #3;
    ResetN = 1'b0;
    #1;
    chk("ar_valid",   64'(OutValid), 64'd0);
    chk("ar_data",    OutData, 64'd0);
    chk("ar_count",   64'(Count), 64'd0);
    chk("ar_stall",   64'(StallCnt), 64'd0);
    chk("ar_inready", 64'(InReady), 64'd1);
    tick();
    ResetN = 1'b1; InData = 64'h33; OutReady = 1'b1;
    tick();
    chk("ar_post_valid", 64'(OutValid), 64'd1);
    chk("ar_post_data",  OutData, 64'h33);
    chk("ar_post_count", 64'(Count), 64'd1);
    InValid = 1'b0;
    tick();
    chk("ar_post_empty", 64'(Count), 64'd0);

    // ---------------- saturation with CNT_W = 2 ----------------
    OutReady = 1'b0; InValid = 1'b1; InData = 64'h44;
    tick();
    InValid = 1'b0;
    chk("sat_start", 64'(s_StallCnt), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("sat_s_%0d", i), 64'(s_StallCnt), 64'(sat_exp[i]));
      chk($sformatf("sat_m_%0d", i), 64'(StallCnt), 64'(i + 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register that supersedes fixed enable-only stage registers between pipeline stages (e.g. decode→issue). It carries an arbitrary-width payload under a valid/ready handshake and has a 2-entry skid buffer, so upstream ready is fully registered. It adds synchronous flush (bubble injection), a hold input, an occupancy output and a saturating back-pressure counter.

## Interface
- DATA_W, 64, payload width in bits (≥1)
- CLEAR_ON_FLUSH, 1, 1: flush zeroes both payload registers; 0: payload registers keep their contents
- CNT_W, 16, width of the back-pressure counter (≥1)
- CLK  in  1  clock, rising edge
- ResetN  in  1  reset; asynchronous, active-low
- InValid  in  1  upstream offers InData
- InData  in  DATA_W  upstream payload
- InReady  out  1  stage can accept this cycle
- OutValid  out  1  OutData is valid
- OutData  out  DATA_W  payload presented downstream
- OutReady  in  1  downstream accepts
- Flush  in  1  synchronous discard of all held entries and of this cycle's input
- Hold  in  1  freeze: no transfer on either side
- Count  out  2  occupancy, 0..2
- StallCnt  out  CNT_W  saturating count of back-pressured cycles

## Operation
- Storage: Main (payload + valid) drives OutData. Skid (payload + valid) holds overflow.
- States, encoded by the valid bits: EMPTY (neither valid), ONE (Main only), FULL (both valid). Skid valid with Main invalid is illegal and never reached.
- InReady = !SkidValid && !Hold. OutValid = MainValid && !Hold. There is no combinational path from OutReady to InReady.
- Accept = InValid && InReady && !Flush. Emit = OutValid && OutReady && !Flush.
- EMPTY: Accept → ONE, Main ← InData.
- ONE:
  - Accept only → FULL, Skid ← InData.
  - Emit only → EMPTY.
  - Both → ONE, Main ← InData.
  - Neither → ONE, unchanged.
- FULL: InReady = 0. Emit → ONE, Main ← Skid, Skid cleared. Otherwise unchanged.
- Flush (highest priority, overrides Hold):
  - Next state is EMPTY.
  - The InData offered that cycle is dropped. Any OutData handshake that cycle is void.
  - If CLEAR_ON_FLUSH = 1, both payload registers are zeroed.
- Hold without Flush: all registers keep their values. StallCnt does not increment.
- Count = MainValid + SkidValid, registered.
- StallCnt: increments by 1 each cycle that OutValid && !OutReady && !Flush. It saturates at 2^CNT_W − 1 and never wraps. It is cleared only by reset.
- Ordering: strict FIFO. Skid always holds the younger entry.

## Timing
- Reset (ResetN low, async): MainValid = SkidValid = 0, both payloads 0, Count 0, StallCnt 0, OutValid 0, OutData 0. InReady = 1 unless Hold. Deassertion takes effect at the next rising edge.
- Latency: data accepted at edge N is on OutData, with OutValid, from edge N to N+1 (one cycle, when Main is free or being emitted).
- Throughput: 1 transfer/cycle sustained when OutReady is held high.
- InReady falls the cycle after the skid fills. One extra beat is absorbed before it falls, with zero loss.
- Reset asserted mid-transfer: all state discarded immediately. No partial payload survives.
- Simultaneous Flush and Accept: the input is discarded and the state is EMPTY next cycle.
- Simultaneous Emit from FULL and InValid: no accept (InReady = 0). The next cycle is ONE with the former skid payload.

## Test plan
- Reset then stream 0x1,0x2,0x3 with OutReady = 1 → OutData 0x1,0x2,0x3 on consecutive cycles, each 1 cycle after acceptance; Count stays 1; StallCnt 0.
- Accept 0xA, then 0xB, with OutReady = 0 → Count 2, InReady 0, 0xC held off. Raise OutReady → 0xA, 0xB, 0xC emitted in order with no loss; StallCnt = number of stalled cycles.
- FULL state (0xA, 0xB), assert Flush with InValid = 1, InData = 0xC → next cycle Count 0, OutValid 0, 0xC never appears. With CLEAR_ON_FLUSH = 1, OutData = 0.
- Hold = 1 while ONE, OutReady = 1, InValid = 1 → OutValid 0, InReady 0, Count unchanged, StallCnt unchanged. Release Hold → transfers resume with no data lost.
- CNT_W = 2, OutValid high with OutReady low for 6 cycles → StallCnt reads 1, 2, 3, 3, 3, 3 (saturates, no wrap).
- Pull ResetN low mid-stream, asynchronously between edges → outputs reach reset values without waiting for a clock edge. After release, the first accepted datum emerges correctly.
